// File: rtl/hlr_bm2_pkg.sv
// hlr_bm2 shared widths and types.
// Radix-8 Booth approximate multiplier.
package hlr_bm2_pkg;

  localparam int IN_W     = 8;
  localparam int OUT_W    = 16;
  localparam int PP_W     = 10;
  localparam int N_DIGITS = 3;

  typedef logic signed [3:0]      booth_digit_t;
  typedef logic signed [PP_W-1:0] pp_t;
  typedef logic signed [OUT_W-1:0] wide_t;

  typedef struct packed {
    logic       neg;
    logic [2:0] mag;
  } booth_sel_t;

  function automatic pp_t sext_pp(
    input logic [IN_W-1:0] v
  );
    return {{(PP_W-IN_W){v[IN_W-1]}}, v};
  endfunction

  function automatic wide_t sext_wide(
    input pp_t v
  );
    return {{(OUT_W-PP_W){v[PP_W-1]}}, v};
  endfunction

endpackage

// File: rtl/hlr_bm2_mult_booth_r8_enc.sv
// Radix-8 Booth recoder: 4-bit window of y
// to a sign/magnitude digit in -4..4.
module booth_r8_enc
  import hlr_bm2_pkg::*;
(
  input  logic [3:0] i_win,
  output booth_sel_t o_sel
);

  booth_digit_t w_hi;
  booth_digit_t w_lo1;
  booth_digit_t w_lo0;
  booth_digit_t w_d;

  // -4*w3 + 2*w2 as a signed 4-bit value
  assign w_hi  = {i_win[3], i_win[3], i_win[2], 1'b0};
  assign w_lo1 = booth_digit_t'({3'b000, i_win[1]});
  assign w_lo0 = booth_digit_t'({3'b000, i_win[0]});
  assign w_d   = w_hi + w_lo1 + w_lo0;

  assign o_sel.neg = w_d[3];
  assign o_sel.mag = w_d[3] ? (3'b000 - w_d[2:0])
                            : w_d[2:0];

endmodule

// File: rtl/hlr_bm2_mult.sv
// Signed 8x8 approximate radix-8 Booth multiplier
// with registered exact product and error.
module hlr_bm2_mult
  import hlr_bm2_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [IN_W-1:0]  i_a,
  input  logic [IN_W-1:0]  i_b,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_z,
  output logic [OUT_W-1:0] o_z_exact,
  output logic [OUT_W-1:0] o_err
);

  logic [3*N_DIGITS:0] w_ye;
  booth_sel_t          w_sel  [N_DIGITS];
  pp_t                 w_mag  [N_DIGITS];
  wide_t               w_term [N_DIGITS];

  pp_t   w_x1;
  pp_t   w_x2;
  pp_t   w_x4;
  pp_t   w_a3;
  wide_t w_z;
  wide_t w_ae;
  wide_t w_be;
  wide_t w_ze;
  wide_t w_err;

  logic  r_valid;
  wide_t r_z;
  wide_t r_ze;
  wide_t r_err;

  // y sign-extended to 9 bits with y[-1]=0 at bit 0
  assign w_ye = {i_b[IN_W-1], i_b, 1'b0};

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_enc
    booth_r8_enc u_enc (
      .i_win (w_ye[3*g+3:3*g]),
      .o_sel (w_sel[g])
    );
  end

  assign w_x1 = sext_pp(i_a);
  assign w_x2 = w_x1 <<< 1;
  assign w_x4 = w_x1 <<< 2;

  // 3x with the carry out of bit 1 dropped
  assign w_a3[1:0] = w_x2[1:0] | w_x1[1:0];
  assign w_a3[9:2] = w_x2[9:2] + w_x1[9:2];

  always_comb begin
    for (int k = 0; k < N_DIGITS; k++) begin
      w_mag[k] = '0;
      unique case (1'b1)
        (w_sel[k].mag == 3'd1): w_mag[k] = w_x1;
        (w_sel[k].mag == 3'd2): w_mag[k] = w_x2;
        (w_sel[k].mag == 3'd3): w_mag[k] = w_a3;
        (w_sel[k].mag == 3'd4): w_mag[k] = w_x4;
        default:                w_mag[k] = '0;
      endcase
    end
  end

  // Negate after widening so -4*(-128) stays +512
  always_comb begin
    for (int k = 0; k < N_DIGITS; k++) begin
      w_term[k] = sext_wide(w_mag[k]);
      if (w_sel[k].neg) begin
        w_term[k] = -sext_wide(w_mag[k]);
      end
    end
  end

  always_comb begin
    w_z = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      w_z = w_z + (w_term[k] <<< (3*k));
    end
  end

  assign w_ae  = {{(OUT_W-IN_W){i_a[IN_W-1]}}, i_a};
  assign w_be  = {{(OUT_W-IN_W){i_b[IN_W-1]}}, i_b};
  assign w_ze  = w_ae * w_be;
  assign w_err = w_z - w_ze;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_z     <= '0;
      r_ze    <= '0;
      r_err   <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_z   <= w_z;
        r_ze  <= w_ze;
        r_err <= w_err;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_z       = r_z;
  assign o_z_exact = r_ze;
  assign o_err     = r_err;

endmodule

// File: tb/tb_hlr_bm2_mult.sv
// Randomised/exhaustive bench for hlr_bm2_mult
// against an integer Booth reference model.
module tb_hlr_bm2_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        o_valid;
  logic [15:0] o_z;
  logic [15:0] o_z_exact;
  logic [15:0] o_err;

  int checks = 0;
  int failures = 0;

  hlr_bm2_mult dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (valid),
    .i_a       (a),
    .i_b       (b),
    .o_valid   (o_valid),
    .o_z       (o_z),
    .o_z_exact (o_z_exact),
    .o_err     (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sx8(input int v);
    int t;
    t = v & 255;
    return (t > 127) ? t - 256 : t;
  endfunction

  function automatic int ybit(input int y, input int i);
    if (i < 0) return 0;
    return ((y & 511) >> i) & 1;
  endfunction

  function automatic int digit(input int y, input int k);
    return -4 * ybit(y, 3*k+2) + 2 * ybit(y, 3*k+1)
           + ybit(y, 3*k) + ybit(y, 3*k-1);
  endfunction

  function automatic int approx3(input int x);
    int p;
    int lo;
    int hi;
    p  = 2 * x;
    lo = (p & 3) | (x & 3);
    hi = (p >>> 2) + (x >>> 2);
    return hi * 4 + lo;
  endfunction

  function automatic int ref_z(input int x, input int y);
    int z;
    int d;
    int m;
    z = 0;
    for (int k = 0; k < 3; k++) begin
      d = digit(y, k);
      if (d == 3) m = approx3(x);
      else if (d == -3) m = -approx3(x);
      else m = d * x;
      z += m * (1 << (3*k));
    end
    return z;
  endfunction

  function automatic bit has3(input int y);
    for (int k = 0; k < 3; k++) begin
      if (digit(y, k) == 3 || digit(y, k) == -3) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_out(input string tag, input int v,
                           input int ez, input int ex);
    chk({tag, "_valid"}, int'(o_valid), v);
    chk({tag, "_z"}, int'($signed(o_z)), ez);
    chk({tag, "_exact"}, int'($signed(o_z_exact)), ex);
    chk({tag, "_err"}, int'($signed(o_err)), ez - ex);
  endtask

  typedef struct {
    int x;
    int y;
    int ez;
    int ex;
  } vec_t;

  vec_t dir[$];
  int   ez;
  int   ex;
  int   vcnt;
  int   v;
  int   xs;
  int   ys;

  initial begin
    dir.push_back('{3, 3, 7, 9});
    dir.push_back('{-1, 3, -5, -3});
    dir.push_back('{1, 3, 3, 3});
    dir.push_back('{3, 24, 56, 72});
    dir.push_back('{5, 2, 10, 10});
    dir.push_back('{-128, -128, 16384, 16384});
    dir.push_back('{-128, 3, -384, -384});
    dir.push_back('{-128, 4, -512, -512});

    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (dir[i]) begin
      a = 8'(dir[i].x);
      b = 8'(dir[i].y);
      valid = 1'b1;
      @(posedge clk);
      #1;
      check_out($sformatf("dir%0d", i), 1, dir[i].ez, dir[i].ex);
      valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk);
      #1;
      check_out($sformatf("hold%0d", i), 0, dir[i].ez, dir[i].ex);
    end

    vcnt = 0;
    for (int x = 0; x < 256; x++) begin
      for (int y = 0; y < 256; y++) begin
        a = 8'(x);
        b = 8'(y);
        valid = 1'b1;
        @(posedge clk);
        #1;
        xs = sx8(x);
        ys = sx8(y);
        if (o_valid) vcnt++;
        chk("sweep_exact", int'($signed(o_z_exact)), xs * ys);
        chk("sweep_z", int'($signed(o_z)), ref_z(xs, ys));
        chk("sweep_err", int'($signed(o_err)), ref_z(xs, ys) - xs * ys);
        if (!has3(ys)) chk("sweep_err0", int'($signed(o_err)), 0);
      end
    end
    valid = 1'b0;
    chk("vcount", vcnt, 65536);

    ez = ref_z(127, -1);
    ex = -127;
    a = 8'(127);
    b = 8'hff;
    valid = 1'b1;
    @(posedge clk);
    #1;
    check_out("rnd_seed", 1, ez, ex);
    for (int n = 0; n < 2000; n++) begin
      v = int'($urandom_range(0, 1));
      a = 8'($urandom);
      b = 8'($urandom);
      valid = v[0];
      if (v != 0) begin
        xs = sx8(int'(a));
        ys = sx8(int'(b));
        ez = ref_z(xs, ys);
        ex = xs * ys;
      end
      @(posedge clk);
      #1;
      check_out("rnd", v, ez, ex);
    end

    a = 8'(-7);
    b = 8'(11);
    valid = 1'b1;
    @(posedge clk);
    #1;
    check_out("pre_rst", 1, ref_z(-7, 11), -77);
    rst_n = 1'b0;
    #1;
    check_out("rst_now", 0, 0, 0);
    a = 8'(9);
    b = 8'(13);
    @(posedge clk);
    #1;
    check_out("rst_hold", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a = 8'(-100);
    b = 8'(77);
    #1;
    check_out("rel", 0, 0, 0);
    @(posedge clk);
    #1;
    check_out("post_rst", 1, ref_z(-100, 77), -7700);
    valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hlr_bm2_mult.md
# hlr_bm2_mult

Signed 8×8 approximate multiplier built on hybrid low-radix (radix-8) Booth encoding with an approximate ±3x multiple. It also produces the exact product and the signed error, both registered. The block is the device under test for error-metric benches: exhaustive input sweeps, mean error distance and NMED. It sits as a pipelined leaf arithmetic unit behind a single valid strobe.

## Interface
- Parameters: none; widths are fixed by the package.
- i_clk  in  1  rising-edge clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  i_a/i_b are valid this cycle
- i_a  in  8  signed multiplicand x
- i_b  in  8  signed multiplier y
- o_valid  out  1  registered copy of i_valid
- o_z  out  16  signed approximate product
- o_z_exact  out  16  signed exact product x*y
- o_err  out  16  signed o_z − o_z_exact

## Operation
- **Booth digits.** Sign-extend y to 9 bits (y[8]=y[7]) and set y[−1]=0. This yields three radix-8 digits.
  - d_k = −4·y[3k+2] + 2·y[3k+1] + y[3k] + y[3k−1], for k = 0, 1, 2.
  - Each digit d_k lies in {−4..4}.
- **Multiples.** All multiples are formed at 10-bit signed width.
  - 0, ±x, ±2x, ±4x are exact shifts and negations.
  - ±3x uses the approximate multiple A3(x); −3x = −A3(x).
- **A3(x).** Let p = 2x and q = x, both 10-bit sign-extended.
  - A3[1:0] = p[1:0] | q[1:0] (OR, no carry out).
  - A3[9:2] = p[9:2] + q[9:2] (8-bit signed add; the carry out of bit 1 is dropped).
  - Examples: A3(1)=3, A3(3)=7, A3(−1)=−5, A3(−128)=−384.
- **Sum.** The approximation applies to every digit position.
  - o_z = Σ_k PP_k · 8^k, where PP_k is the multiple selected by d_k.
  - Accumulate at 16-bit signed width; the result never overflows.
- **Exact path.** o_z_exact = signed x*y. o_err = o_z − o_z_exact, 16-bit signed, with no saturation.

## Timing
- **Latency.** Exactly 1 cycle. On each rising edge with i_valid=1, o_z, o_z_exact and o_err are loaded from the current i_a/i_b.
- **Idle cycles.** With i_valid=0, the result registers hold their values. o_valid follows i_valid with a 1-cycle delay.
- **Throughput.** One product per cycle. Back-to-back valid inputs produce back-to-back results with no bubbles.
- **Reset.** i_rst_n low asynchronously clears o_valid, o_z, o_z_exact and o_err to 0.
  - Reset wins over a simultaneous valid input.
  - An input sampled while in reset is discarded.
  - The first result appears 1 cycle after the first valid input following reset release.
- **Combinational path.** From the input pins to the output registers only; there is no combinational input-to-output path.

## Structure
- **Package hlr_bm2_pkg** holds:
  - IN_W=8, OUT_W=16, PP_W=10, N_DIGITS=3.
  - Typedef booth_digit_t: signed 4-bit.
  - Typedef pp_t: signed 10-bit.
- **Sub-module booth_r8_enc:** converts one 4-bit window of y into a digit (sign, magnitude 0–4). It is instantiated 3 times.
- **Top level** contains:
  - the A3 generator;
  - the per-digit multiple mux;
  - the shifted partial-product adder;
  - the exact multiplier;
  - the error subtractor;
  - the output registers.

## Test plan
- x=3, y=3 (d0=3) -> o_z=7, o_z_exact=9, o_err=−2, one cycle after i_valid.
- x=−1, y=3 -> o_z=−5, o_z_exact=−3, o_err=−2; x=1, y=3 -> o_z=3, o_err=0.
- x=3, y=24 (d1=3) -> o_z=56, o_z_exact=72, o_err=−16; x=5, y=2 -> o_z=10, o_err=0.
- Corners: x=−128, y=−128 -> o_z=o_z_exact=16384. x=−128, y=3 -> o_z=−384=o_z_exact, o_err=0.
- Exhaustive sweep of 65536 pairs, back-to-back valid:
  - o_z_exact matches the reference product on every pair.
  - o_err is 0 for every y whose digits avoid ±3.
  - o_valid count equals 65536.
- Assert i_rst_n=0 mid-stream with i_valid=1 -> all outputs 0 immediately. After release, the first valid pair appears exactly one cycle later.
